seq_pattern_gen: RTL
====================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter MAX_LEN, default 8: width of the pattern register and maximum pattern length in bits.
REQ-003 Parameter GAP_CYCLES, default 0: idle cycles inserted between repeats of a pattern.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 pat_valid  input  1  pattern load request.
REQ-007 pat_ready  output  1  block can accept a pattern.
REQ-008 pat_data  input  MAX_LEN  pattern bits; the first bit sent is pat_data[pat_len-1].
REQ-009 pat_len  input  4  number of bits to send, 0..15.
REQ-010 pat_rpt  input  4  extra repeats; transmissions = pat_rpt+1.
REQ-011 abort  input  1  synchronous cancel of the current transmission.
REQ-012 seq  output  1  serial bit stream driven to the sequence detector.
REQ-013 seq_valid  output  1  seq carries a pattern bit this cycle.
REQ-014 busy  output  1  a transmission is in progress.
REQ-015 done  output  1  one-cycle pulse after the final bit of the final repeat.

Function
REQ-016 The state machine SHALL have the states IDLE, SHIFT, GAP and DONE, and all outputs SHALL be registered.
REQ-017 pat_ready SHALL be 1 only in IDLE, and busy SHALL be 1 in SHIFT, GAP and DONE.
REQ-018 A load SHALL be accepted on a rising edge where pat_valid=1 and pat_ready=1, capturing pat_data, the effective length and pat_rpt.
REQ-019 The effective length SHALL be min(pat_len, MAX_LEN).
REQ-020 A pat_len of 0 SHALL go IDLE->DONE directly, send no bits, and pulse done in the cycle after accept.
REQ-021 IDLE->SHIFT on accept; in the first cycle after accept, seq SHALL equal the MSB of the captured pattern and seq_valid SHALL be 1.
REQ-022 In SHIFT, one bit SHALL be sent per cycle, MSB-first, for exactly the effective length in cycles.
REQ-023 On the last bit: if repeats remain and GAP_CYCLES>0, go to GAP; if repeats remain and GAP_CYCLES=0, stay in SHIFT and send the MSB again in the next cycle with no bubble; if no repeats remain, go to DONE.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles with seq=0 and seq_valid=0, then return to SHIFT starting from the MSB.
REQ-025 The repeat counter SHALL decrement once per completed pattern, with no wrap below 0.
REQ-026 DONE SHALL last one cycle with done=1, seq=0 and seq_valid=0, then go to IDLE.
REQ-027 pat_ready SHALL be 1 in the cycle after done.
REQ-028 Outside SHIFT, seq=0 and seq_valid=0.
REQ-029 pat_valid outside IDLE SHALL be ignored, and the held pattern SHALL NOT change.
REQ-030 abort=1 in SHIFT, GAP or DONE SHALL force IDLE on the next edge with no done pulse, and seq_valid=0 from that edge.
REQ-031 abort=1 in the same cycle as an accept SHALL take precedence: the pattern is not loaded and the block stays in IDLE.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 Back-to-back operation: with pat_valid held at 1, a new pattern SHALL be accepted in the first IDLE cycle, giving a minimum spacing of 2 non-valid cycles between patterns.

Reset
REQ-034 While rst=1, asynchronously: state=IDLE, seq=0, seq_valid=0, busy=0, done=0, pat_ready=1, and all counters and the pattern register cleared.
REQ-035 Reset asserted mid-transmission SHALL discard the pattern without a done pulse.
REQ-036 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-037 MAX_LEN=8, GAP=0: load data=8'b0000_0101, len=4, rpt=0 -> seq 0,1,0,1 in cycles +1..+4 with seq_valid=1; done at +5; pat_ready at +6.
REQ-038 Load len=4, data=0110, rpt=2, GAP=0 -> 12 contiguous valid bits 0110_0110_0110; a single done at +13.
REQ-039 GAP_CYCLES=2, len=3, data=101, rpt=1 -> 1,0,1 / two cycles with seq_valid=0 / 1,0,1; then done.
REQ-040 Load len=0 -> seq_valid never 1; done at +1. Load len=12 with MAX_LEN=8 -> 8 bits sent.
REQ-041 abort at the 3rd bit of a len=8 pattern -> seq_valid=0 and pat_ready=1 from the next edge; no done pulse.
REQ-042 rst=1 asserted mid-SHIFT, between edges -> outputs immediately at reset values; the bench loops the stream into the sequence detector and checks that the detector asserts only for complete patterns.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serialises a captured pattern MSB-first, repeating it
// pat_rpt+1 times with GAP_CYCLES idle cycles between repeats, then pulses
// done. Every output comes straight from a flop.
module seq_pattern_gen #(
  parameter int MAX_LEN    = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pat_valid,
  output logic               pat_ready,
  input  logic [MAX_LEN-1:0] pat_data,
  input  logic [3:0]         pat_len,
  input  logic [3:0]         pat_rpt,
  input  logic               abort,
  output logic               seq,
  output logic               seq_valid,
  output logic               busy,
  output logic               done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Registered state and datapath
  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [3:0]         r_len;
  logic [3:0]         r_rpt;
  logic [3:0]         r_idx;
  logic [GW-1:0]      r_gap;
  logic               r_seq;
  logic               r_seq_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;

  // Next-state values
  state_t             w_state;
  logic [MAX_LEN-1:0] w_pat;
  logic [3:0]         w_len;
  logic [3:0]         w_rpt;
  logic [3:0]         w_idx;
  logic [GW-1:0]      w_gap;
  logic               w_seq;
  logic               w_seq_valid;
  logic               w_done;
  logic [3:0]         w_eff_len;
  logic [3:0]         w_last_idx;

  // Select one bit of the pattern by a 4-bit index; indices beyond the
  // register read as 0 (never reached because the length is clamped).
  function automatic logic pick_bit(input logic [MAX_LEN-1:0] pat,
                                    input logic [3:0]         idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i == int'(idx)) b = pat[i];
    end
    return b;
  endfunction

  // Requested lengths longer than the pattern register are clamped to it.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (int'(len) > MAX_LEN) return 4'(MAX_LEN);
    return len;
  endfunction

  assign w_eff_len  = clamp_len(pat_len);
  assign w_last_idx = r_len - 4'd1;

  // Next-state, next-datapath and next-output decode
  always_comb begin
    w_state     = r_state;
    w_pat       = r_pat;
    w_len       = r_len;
    w_rpt       = r_rpt;
    w_idx       = r_idx;
    w_gap       = r_gap;
    w_seq       = 1'b0;
    w_seq_valid = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      IDLE: begin
        // abort on the accept edge wins: nothing is captured
        if (pat_valid && !abort) begin
          w_pat = pat_data;
          w_len = w_eff_len;
          w_rpt = pat_rpt;
          if (w_eff_len == 4'd0) begin
            w_state = DONE;
            w_done  = 1'b1;
          end else begin
            w_state     = SHIFT;
            w_idx       = w_eff_len - 4'd1;
            w_seq       = pick_bit(pat_data, w_eff_len - 4'd1);
            w_seq_valid = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (abort) begin
          w_state = IDLE;
        end else if (r_idx != 4'd0) begin
          w_idx       = r_idx - 4'd1;
          w_seq       = pick_bit(r_pat, r_idx - 4'd1);
          w_seq_valid = 1'b1;
        end else if (r_rpt != 4'd0) begin
          w_rpt = r_rpt - 4'd1;
          if (GAP_CYCLES > 0) begin
            w_state = GAP;
            w_gap   = GW'(GAP_CYCLES - 1);
          end else begin
            // no gap: restart from the MSB on the very next cycle
            w_idx       = w_last_idx;
            w_seq       = pick_bit(r_pat, w_last_idx);
            w_seq_valid = 1'b1;
          end
        end else begin
          w_state = DONE;
          w_done  = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          w_state = IDLE;
        end else if (r_gap == '0) begin
          w_state     = SHIFT;
          w_idx       = w_last_idx;
          w_seq       = pick_bit(r_pat, w_last_idx);
          w_seq_valid = 1'b1;
        end else begin
          w_gap = r_gap - GW'(1);
        end
      end

      DONE: begin
        w_state = IDLE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pat       <= '0;
      r_len       <= '0;
      r_rpt       <= '0;
      r_idx       <= '0;
      r_gap       <= '0;
      r_seq       <= 1'b0;
      r_seq_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_pat       <= w_pat;
      r_len       <= w_len;
      r_rpt       <= w_rpt;
      r_idx       <= w_idx;
      r_gap       <= w_gap;
      r_seq       <= w_seq;
      r_seq_valid <= w_seq_valid;
      r_busy      <= (w_state != IDLE);
      r_done      <= w_done;
      r_ready     <= (w_state == IDLE);
    end
  end

  assign seq       = r_seq;
  assign seq_valid = r_seq_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pat_ready = r_ready;

endmodule
